// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/ready handshake.
// state | meaning
// IDLE  | waiting for en
// BUSY  | shifting/subtracting, one quotient bit per edge
// DONE  | result registered, data_rdy high for this cycle
module seq_div #(
   parameter int N     = 256,
   parameter int CNT_W = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] quot,
   output logic [N-1:0] rem,
   output logic         busy,
   output logic         data_rdy,
   output logic         div_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           r_state;
   logic [N-1:0]     r_q;
   logic [N:0]       r_r;
   logic [N-1:0]     r_d;
   logic [CNT_W-1:0] r_cnt;
   logic [N-1:0]     r_quot;
   logic [N-1:0]     r_rem;
   logic             r_busy;
   logic             r_data_rdy;
   logic             r_div_zero;

   logic [N:0]       w_s;
   logic [N:0]       w_t;
   logic [N-1:0]     w_q_nxt;
   logic [N:0]       w_r_nxt;

   // A clear borrow bit means the divisor fit: keep the difference, shift in a 1.
   always_comb begin
      w_s     = {r_r[N-1:0], r_q[N-1]};
      w_t     = w_s - {1'b0, r_d};
      w_q_nxt = {r_q[N-2:0], ~w_t[N]};
      w_r_nxt = w_t[N] ? w_s : w_t;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_q        <= '0;
         r_r        <= '0;
         r_d        <= '0;
         r_cnt      <= '0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_busy     <= 1'b0;
         r_data_rdy <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_data_rdy <= 1'b0;
         if (en) begin
            r_d        <= b;
            r_q        <= a;
            r_r        <= '0;
            r_cnt      <= CNT_INIT;
            r_div_zero <= 1'b0;
            if (b == '0) begin
               // Divide by zero lands its result immediately, no iteration.
               r_state    <= DONE;
               r_busy     <= 1'b0;
               r_quot     <= '1;
               r_rem      <= a;
               r_div_zero <= 1'b1;
               r_data_rdy <= 1'b1;
            end else begin
               r_state <= BUSY;
               r_busy  <= 1'b1;
            end
         end else begin
            case (r_state)
               IDLE: begin
                  r_busy <= 1'b0;
               end
               BUSY: begin
                  r_q   <= w_q_nxt;
                  r_r   <= w_r_nxt;
                  r_cnt <= r_cnt - CNT_ONE;
                  if (r_cnt == CNT_ONE) begin
                     r_state    <= DONE;
                     r_busy     <= 1'b0;
                     r_quot     <= w_q_nxt;
                     r_rem      <= w_r_nxt[N-1:0];
                     r_data_rdy <= 1'b1;
                  end
               end
               DONE: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign quot     = r_quot;
   assign rem      = r_rem;
   assign busy     = r_busy;
   assign data_rdy = r_data_rdy;
   assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div at N=256: latency, results, divide-by-zero, restart and reset abort.
module tb_seq_div;
   localparam int N   = 256;
   localparam int LIM = 400;

   logic         clk;
   logic         rst;
   logic         en;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] quot;
   logic [N-1:0] rem;
   logic         busy;
   logic         data_rdy;
   logic         div_zero;

   int n_pass;
   int n_total;

   seq_div #(.N(N)) dut (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
      .quot(quot), .rem(rem), .busy(busy), .data_rdy(data_rdy), .div_zero(div_zero)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Called at a negedge; en is seen by the next posedge, returns at the following negedge.
   task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb);
      a  = ta;
      b  = tb;
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
   endtask

   // Counts posedges after the start edge until data_rdy is seen; LIM on timeout.
   task automatic wait_rdy(output int cycles);
      cycles = 0;
      while (data_rdy !== 1'b1 && cycles < LIM) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      en  = 1'b0;
      a   = '0;
      b   = '0;
      #1;
      n_total++;
      if ({quot, rem, busy, data_rdy, div_zero} !== '0)
         $display("FAIL reset_outputs: quot=%h rem=%h busy=%b rdy=%b dz=%b, want all 0",
                  quot, rem, busy, data_rdy, div_zero);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({busy, data_rdy} !== 2'b00)
         $display("FAIL reset_idle: busy=%b rdy=%b, want 0 0", busy, data_rdy);
      else n_pass++;
   endtask

   task automatic test_divide;
      logic [N-1:0]   va [8];
      logic [N-1:0]   vb [8];
      logic [N-1:0]   vq [8];
      logic [N-1:0]   vr [8];
      logic [2*N-1:0] prod;
      logic [2*N-1:0] wq;
      logic [2*N-1:0] wb;
      logic [2*N-1:0] wr;
      int             cyc;
      va[0] = 60;  vb[0] = 12; vq[0] = 5;   vr[0] = 0;
      va[1] = 61;  vb[1] = 12; vq[1] = 5;   vr[1] = 1;
      va[2] = 5;   vb[2] = 12; vq[2] = 0;   vr[2] = 5;
      va[3] = '1;  vb[3] = 2;  vq[3] = {1'b0, {(N-1){1'b1}}}; vr[3] = 1;
      va[4] = '1;  vb[4] = '1; vq[4] = 1;   vr[4] = 0;
      va[5] = 1000; vb[5] = 10; vq[5] = 100; vr[5] = 0;
      va[6] = 0;   vb[6] = 5;  vq[6] = 0;   vr[6] = 0;
      va[7] = {8{32'h1234_5678}}; vb[7] = 1; vq[7] = {8{32'h1234_5678}}; vr[7] = 0;
      for (int i = 0; i < 8; i++) begin
         start_op(va[i], vb[i]);
         n_total++;
         if (busy !== 1'b1) $display("FAIL div%0d_busy: busy=%b, want 1", i, busy);
         else n_pass++;
         wait_rdy(cyc);
         n_total++;
         if (cyc != N) $display("FAIL div%0d_latency: %0d cycles, want %0d", i, cyc, N);
         else n_pass++;
         n_total++;
         if (quot !== vq[i] || rem !== vr[i] || div_zero !== 1'b0)
            $display("FAIL div%0d_result: quot=%h rem=%h dz=%b, want quot=%h rem=%h dz=0",
                     i, quot, rem, div_zero, vq[i], vr[i]);
         else n_pass++;
         wq   = {{N{1'b0}}, quot};
         wb   = {{N{1'b0}}, vb[i]};
         wr   = {{N{1'b0}}, rem};
         prod = wq * wb + wr;
         n_total++;
         if (prod !== {{N{1'b0}}, va[i]} || rem >= vb[i])
            $display("FAIL div%0d_invariant: quot*b+rem=%h rem=%h, want a=%h and rem<b=%h",
                     i, prod, rem, va[i], vb[i]);
         else n_pass++;
         @(negedge clk);
         n_total++;
         if (data_rdy !== 1'b0 || busy !== 1'b0 || quot !== vq[i])
            $display("FAIL div%0d_pulse: rdy=%b busy=%b quot=%h, want 0 0 %h",
                     i, data_rdy, busy, quot, vq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_div_zero;
      logic [N-1:0] pat;
      int           cyc;
      pat = {8{32'hDEAD_BEEF}};
      start_op(pat, '0);
      wait_rdy(cyc);
      n_total++;
      if (cyc != 0) $display("FAIL dz_latency: %0d cycles, want 0", cyc);
      else n_pass++;
      n_total++;
      if (quot !== {N{1'b1}} || rem !== pat || div_zero !== 1'b1 || busy !== 1'b0)
         $display("FAIL dz_result: quot=%h rem=%h dz=%b busy=%b, want all-ones, a, 1, 0",
                  quot, rem, div_zero, busy);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (data_rdy !== 1'b0 || div_zero !== 1'b1)
         $display("FAIL dz_hold: rdy=%b dz=%b, want 0 1", data_rdy, div_zero);
      else n_pass++;
      start_op(60, 12);
      n_total++;
      if (div_zero !== 1'b0 || quot !== {N{1'b1}} || rem !== pat)
         $display("FAIL dz_restart: dz=%b quot=%h rem=%h, want dz=0 and old result held",
                  div_zero, quot, rem);
      else n_pass++;
      wait_rdy(cyc);
      n_total++;
      if (cyc != N || quot !== 5 || rem !== 0)
         $display("FAIL dz_followup: cycles=%0d quot=%h rem=%h, want %0d 5 0", cyc, quot, rem, N);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_restart;
      int cyc;
      int early;
      start_op(60, 12);
      early = 0;
      for (int i = 0; i < 99; i++) begin
         if (data_rdy !== 1'b0 || busy !== 1'b1) early++;
         @(negedge clk);
      end
      n_total++;
      if (early != 0) $display("FAIL restart_first_busy: %0d bad cycles, want 0", early);
      else n_pass++;
      start_op(100, 7);
      wait_rdy(cyc);
      n_total++;
      if (cyc != N) $display("FAIL restart_latency: %0d cycles, want %0d", cyc, N);
      else n_pass++;
      n_total++;
      if (quot !== 14 || rem !== 2)
         $display("FAIL restart_result: quot=%h rem=%h, want 14 2", quot, rem);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_busy;
      int cyc;
      int stray;
      start_op(1000, 10);
      repeat (50) @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_total++;
      if ({quot, rem, busy, data_rdy, div_zero} !== '0)
         $display("FAIL rst_mid_outputs: quot=%h rem=%h busy=%b rdy=%b dz=%b, want all 0",
                  quot, rem, busy, data_rdy, div_zero);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      stray = 0;
      for (int i = 0; i < N + 4; i++) begin
         @(negedge clk);
         if (data_rdy !== 1'b0 || busy !== 1'b0) stray++;
      end
      n_total++;
      if (stray != 0) $display("FAIL rst_mid_no_rdy: %0d stray cycles, want 0", stray);
      else n_pass++;
      start_op(1000, 10);
      wait_rdy(cyc);
      n_total++;
      if (cyc != N || quot !== 100 || rem !== 0)
         $display("FAIL rst_mid_followup: cycles=%0d quot=%h rem=%h, want %0d 100 0",
                  cyc, quot, rem, N);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int cyc;
      start_op(61, 12);
      wait_rdy(cyc);
      n_total++;
      if (cyc != N || data_rdy !== 1'b1 || quot !== 5 || rem !== 1)
         $display("FAIL b2b_first: cycles=%0d rdy=%b quot=%h rem=%h, want %0d 1 5 1",
                  cyc, data_rdy, quot, rem, N);
      else n_pass++;
      // Start again during the DONE cycle.
      start_op(100, 7);
      n_total++;
      if (busy !== 1'b1 || data_rdy !== 1'b0 || quot !== 5)
         $display("FAIL b2b_second_start: busy=%b rdy=%b quot=%h, want 1 0 5", busy, data_rdy, quot);
      else n_pass++;
      wait_rdy(cyc);
      n_total++;
      if (cyc != N || quot !== 14 || rem !== 2)
         $display("FAIL b2b_second: cycles=%0d quot=%h rem=%h, want %0d 14 2", cyc, quot, rem, N);
      else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset;
      test_divide;
      test_div_zero;
      test_restart;
      test_reset_mid_busy;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
